mcdf_arbiter: RTL and testbench
===============================

Name: mcdf_arbiter

Overview:
- Consumer end of the slave-FIFO read handshake (req / ack / val / data).
- Arbitrates among NCH slave FIFOs and issues one-cycle read acks.
- Captures the returned word and forwards it, tagged with its channel id, to the downstream formatter under a valid/ready handshake.
- Sits between the per-channel slave FIFOs and the formatter. Priorities and enables come from the register block.

Parameters:
- NCH, 3, number of slave channels (2..4)
- DW, 32, data word width
- BURST_LEN, 4, maximum consecutive words served to one channel before re-arbitration (1..16)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- slv_req_i  in  NCH  per-channel "FIFO non-empty" request
- slv_val_i  in  NCH  per-channel read-data valid; expected one cycle after ack
- slv_data_i  in  NCH*DW  per-channel read data; channel n occupies bits [n*DW +: DW]
- slv_prio_i  in  NCH*2  per-channel priority; 0 is highest
- slv_en_i  in  NCH  per-channel enable from registers
- a2s_ack_o  out  NCH  one-hot read ack, one cycle per word
- arb_val_o  out  1  output word valid
- arb_id_o  out  2  channel index of the output word
- arb_data_o  out  DW  output word
- fmt_ready_i  in  1  formatter accepts the word when arb_val_o && fmt_ready_i
- arb_err_o  out  1  one-cycle pulse: val missing after ack

Behaviour:
- Reset values: a2s_ack_o=0, arb_val_o=0, arb_id_o=0, arb_data_o=0, arb_err_o=0, state=IDLE, gnt=0, last_gnt=NCH-1, burst_cnt=0.
- Eligible channel: slv_req_i[n] && slv_en_i[n].
- Arbitration: pick the lowest slv_prio_i value among eligible channels. On a tie, round-robin starting at last_gnt+1 mod NCH.
- State machine (single outstanding read):
  - IDLE: if any channel is eligible, register gnt and go to ACK (decision on cycle T). Otherwise stay.
  - ACK (T+1): a2s_ack_o[gnt]=1 for exactly one cycle, decoded from registered state/gnt. Go to CAPT.
  - CAPT (T+2):
    - If slv_val_i[gnt]=1: capture slv_data_i[gnt] into arb_data_o and gnt into arb_id_o; go to SEND.
    - Else: pulse arb_err_o, set last_gnt=gnt, clear burst_cnt, go to IDLE.
  - SEND (T+3 onward): arb_val_o=1. arb_data_o and arb_id_o hold stable until fmt_ready_i=1. On acceptance:
    - If burst_cnt < BURST_LEN-1 and slv_req_i[gnt] && slv_en_i[gnt]: burst_cnt+1, go to ACK with the same gnt.
    - Else: last_gnt=gnt, burst_cnt=0, go to IDLE.
- Latency: minimum 4 cycles from request visible in IDLE to first arb_val_o. A back-to-back burst word costs 3 cycles with fmt_ready_i held at 1.
- Priority or enable changes take effect only at the next IDLE decision. A channel disabled mid-burst finishes its current word, then the burst ends.
- At most one a2s_ack_o bit is ever high. No ack is issued while arb_val_o=1.
- burst_cnt is sized clog2(BURST_LEN). With BURST_LEN=1, every word re-arbitrates.
- Asynchronous reset mid-transfer drops any captured word and returns all outputs to reset values immediately. The slave FIFOs reset alongside.

Decomposition:
- Shared package mcdf_pkg:
  - state enum (IDLE, ACK, CAPT, SEND)
  - PRIO_W=2, ID_W=2
  - default NCH, DW, BURST_LEN
- Sub-module mcdf_rr_prio_sel: combinational priority + round-robin selector.
  - Inputs: eligible vector, packed priorities, last_gnt.
  - Outputs: any_eligible, gnt index.
  - Verified standalone.

Test Plan:
- Single word: ch1 req, prio all 0, fmt_ready_i=1.
  -> a2s_ack_o=3'b010 at T+1, capture at T+2, arb_val_o=1 with id=1 and data=ch1 word at T+3, return to IDLE.
- Priority: ch0 prio=2, ch2 prio=1, both requesting.
  -> ch2 served first (up to BURST_LEN=4 words if its req stays high), then ch0.
- Round-robin: all three channels prio=0, each holding 8 words, BURST_LEN=4.
  -> grant order ch0, ch1, ch2, ch0, ch1, ch2; 4 words per grant; ids in sequence.
- Backpressure: fmt_ready_i=0 for 10 cycles during SEND.
  -> arb_val_o, data and id stable throughout; no ack issued; resumes on ready.
- Protocol error: slave model withholds val after ack.
  -> arb_err_o pulses at T+2, no arb_val_o, arbiter in IDLE at T+3.
- Reset: rstn_i low during SEND.
  -> all outputs 0 immediately; after release, first grant goes to the highest-priority requester with last_gnt=NCH-1.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared types and defaults for the MCDF slave-FIFO arbiter.
// Holds the FSM state type, field widths and default parameter values.
package mcdf_pkg;

    localparam int PRIO_W        = 2;
    localparam int ID_W          = 2;
    localparam int DEF_NCH       = 3;
    localparam int DEF_DW        = 32;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        CAPT,
        SEND
    } state_e;

endpackage

// File: rtl/mcdf_rr_prio_sel.sv
// Combinational selector: lowest priority value wins, ties go to the first
// eligible channel in round-robin order starting after last_gnt_i.
module mcdf_rr_prio_sel
    import mcdf_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic [NCH-1:0]        elig_i,
    input  logic [NCH*PRIO_W-1:0] prio_i,
    input  logic [ID_W-1:0]       last_gnt_i,
    output logic                  any_o,
    output logic [ID_W-1:0]       gnt_o
);

    int rank;
    int key;
    int best;

    // Priority dominates the key; round-robin distance only breaks ties.
    always_comb begin
        any_o = 1'b0;
        gnt_o = '0;
        best  = NCH << PRIO_W;
        rank  = 0;
        key   = 0;
        for (int n = 0; n < NCH; n++) begin
            rank = n - int'(last_gnt_i) - 1;
            if (rank < 0) begin
                rank = rank + NCH;
            end
            key = int'(prio_i[n*PRIO_W +: PRIO_W]) * NCH + rank;
            if (elig_i[n] && (key < best)) begin
                best  = key;
                gnt_o = ID_W'(n);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// Slave-FIFO read arbiter: one outstanding ack/val read, word forwarded with its channel id.
// First word 4 cycles after request, 3 cycles per burst word; output holds while fmt_ready_i is low.
module mcdf_arbiter
    import mcdf_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int DW        = DEF_DW,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NCH-1:0]        slv_req_i,
    input  logic [NCH-1:0]        slv_val_i,
    input  logic [NCH*DW-1:0]     slv_data_i,
    input  logic [NCH*PRIO_W-1:0] slv_prio_i,
    input  logic [NCH-1:0]        slv_en_i,
    output logic [NCH-1:0]        a2s_ack_o,
    output logic                  arb_val_o,
    output logic [ID_W-1:0]       arb_id_o,
    output logic [DW-1:0]         arb_data_o,
    input  logic                  fmt_ready_i,
    output logic                  arb_err_o
);

    localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]  last_gnt_q, last_gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]    data_q, data_d;

    logic [NCH-1:0]   elig;
    logic             any_elig;
    logic [ID_W-1:0]  sel_gnt;
    logic             cur_val;
    logic             cur_elig;
    logic [DW-1:0]    cur_data;
    logic             err;

    assign elig = slv_req_i & slv_en_i;

    mcdf_rr_prio_sel #(
        .NCH (NCH)
    ) u_sel (
        .elig_i     (elig),
        .prio_i     (slv_prio_i),
        .last_gnt_i (last_gnt_q),
        .any_o      (any_elig),
        .gnt_o      (sel_gnt)
    );

    // Per-channel view of the currently granted slave.
    always_comb begin
        cur_val  = 1'b0;
        cur_elig = 1'b0;
        cur_data = '0;
        for (int n = 0; n < NCH; n++) begin
            if (gnt_q == ID_W'(n)) begin
                cur_val  = slv_val_i[n];
                cur_elig = elig[n];
                cur_data = slv_data_i[n*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        id_d        = id_q;
        err         = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    gnt_d   = sel_gnt;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = CAPT;
            end
            CAPT: begin
                if (cur_val) begin
                    data_d  = cur_data;
                    id_d    = gnt_q;
                    state_d = SEND;
                end else begin
                    err         = 1'b1;
                    last_gnt_d  = gnt_q;
                    burst_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            SEND: begin
                if (fmt_ready_i) begin
                    // Enable is re-sampled here so a disabled channel stops after this word.
                    if ((burst_cnt_q < CNT_LAST) && cur_elig) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        state_d     = ACK;
                    end else begin
                        last_gnt_d  = gnt_q;
                        burst_cnt_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        a2s_ack_o = '0;
        for (int n = 0; n < NCH; n++) begin
            a2s_ack_o[n] = (state_q == ACK) && (gnt_q == ID_W'(n));
        end
    end

    assign arb_val_o  = (state_q == SEND);
    assign arb_id_o   = id_q;
    assign arb_data_o = data_q;
    assign arb_err_o  = err;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= LAST_RST;
            burst_cnt_q <= '0;
            data_q      <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            id_q        <= id_d;
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Bench for mcdf_arbiter: slave FIFO models, randomized traffic and a
// transaction-timeline reference model of arbitration and the read handshake.
module tb_mcdf_arbiter;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int BL  = 4;

    localparam int P_IDLE = 0;
    localparam int P_ACK  = 1;
    localparam int P_CAPT = 2;
    localparam int P_SEND = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [NCH-1:0]    slv_req_i;
    logic [NCH-1:0]    slv_val_i;
    logic [NCH*DW-1:0] slv_data_i;
    logic [NCH*2-1:0]  slv_prio_i;
    logic [NCH-1:0]    slv_en_i;
    logic [NCH-1:0]    a2s_ack_o;
    logic              arb_val_o;
    logic [1:0]        arb_id_o;
    logic [DW-1:0]     arb_data_o;
    logic              fmt_ready_i;
    logic              arb_err_o;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter #(
        .NCH       (NCH),
        .DW        (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .slv_req_i   (slv_req_i),
        .slv_val_i   (slv_val_i),
        .slv_data_i  (slv_data_i),
        .slv_prio_i  (slv_prio_i),
        .slv_en_i    (slv_en_i),
        .a2s_ack_o   (a2s_ack_o),
        .arb_val_o   (arb_val_o),
        .arb_id_o    (arb_id_o),
        .arb_data_o  (arb_data_o),
        .fmt_ready_i (fmt_ready_i),
        .arb_err_o   (arb_err_o)
    );

    int checks = 0;
    int errors = 0;

    // Slave FIFO contents, indexed modulo 64.
    logic [DW-1:0] mem [NCH][64];
    int            wr [NCH];
    int            rd [NCH];

    // Reference model: expected activity of the upcoming cycle.
    int            m_ph;
    int            m_ch;
    int            m_cnt;
    int            m_last;
    logic          m_hold;
    logic [DW-1:0] m_data;

    logic [NCH-1:0]   en_cfg;
    logic [NCH*2-1:0] prio_cfg;
    int               rand_cfg;
    int               ready_pct;
    int               err_pct;
    int               push_pct;
    int               rec;
    int               glog[$];
    int               wlog[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int prio_of(input logic [NCH*2-1:0] pr, input int c);
        logic [NCH*2-1:0] t;
        t = pr >> (2 * c);
        return int'(t[1:0]);
    endfunction

    // Lowest priority value first; among those, first one after 'last' in circular order.
    function automatic int pick(input logic [NCH-1:0] el, input logic [NCH*2-1:0] pr, input int last);
        int minp;
        int c;
        minp = 4;
        for (int n = 0; n < NCH; n++) begin
            if (el[n] && prio_of(pr, n) < minp) minp = prio_of(pr, n);
        end
        for (int k = 1; k <= NCH; k++) begin
            c = (last + k) % NCH;
            if (el[c] && prio_of(pr, c) == minp) return c;
        end
        return -1;
    endfunction

    task automatic push(input int n, input logic [DW-1:0] w);
        mem[n][wr[n] % 64] = w;
        wr[n]++;
    endtask

    task automatic drive();
        logic [NCH-1:0] req;
        if (rand_cfg != 0) begin
            if ($urandom_range(0, 19) == 0) prio_cfg = 6'($urandom);
            if ($urandom_range(0, 19) == 0) en_cfg = 3'($urandom);
        end
        for (int n = 0; n < NCH; n++) begin
            if ((wr[n] - rd[n] < 60) && ($urandom_range(0, 99) < push_pct)) push(n, $urandom);
        end
        slv_val_i = '0;
        for (int n = 0; n < NCH; n++) slv_data_i[n*DW +: DW] = $urandom;
        if (m_ph == P_CAPT && !m_hold) begin
            m_data = mem[m_ch][rd[m_ch] % 64];
            rd[m_ch]++;
            slv_val_i[m_ch] = 1'b1;
            slv_data_i[m_ch*DW +: DW] = m_data;
        end
        for (int n = 0; n < NCH; n++) req[n] = (wr[n] != rd[n]);
        slv_req_i   = req;
        slv_en_i    = en_cfg;
        slv_prio_i  = prio_cfg;
        fmt_ready_i = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic check_cycle();
        logic [NCH-1:0] el;
        logic [NCH-1:0] exp_ack;
        int             obs;
        el      = slv_req_i & slv_en_i;
        exp_ack = (m_ph == P_ACK) ? 3'(1 << m_ch) : 3'b000;
        check_eq("ack", 64'(a2s_ack_o), 64'(exp_ack));
        check_eq("val", 64'(arb_val_o), 64'(m_ph == P_SEND));
        check_eq("err", 64'(arb_err_o), 64'(m_ph == P_CAPT && m_hold));
        case (m_ph)
            P_IDLE: begin
                if (el != '0) begin
                    m_ch  = pick(el, slv_prio_i, m_last);
                    m_cnt = 0;
                    m_ph  = P_ACK;
                end
            end
            P_ACK: begin
                if (rec != 0 && m_cnt == 0) begin
                    obs = -1;
                    for (int n = 0; n < NCH; n++) if (a2s_ack_o[n]) obs = n;
                    glog.push_back(obs);
                end
                m_hold = ($urandom_range(0, 99) < err_pct);
                m_ph   = P_CAPT;
            end
            P_CAPT: begin
                if (m_hold) begin
                    m_last = m_ch;
                    m_ph   = P_IDLE;
                end else begin
                    m_ph = P_SEND;
                end
            end
            default: begin
                check_eq("id", 64'(arb_id_o), 64'(m_ch));
                check_eq("data", 64'(arb_data_o), 64'(m_data));
                if (fmt_ready_i) begin
                    if (rec != 0) wlog.push_back(int'(arb_id_o));
                    m_cnt++;
                    if (m_cnt < BL && el[m_ch]) begin
                        m_ph = P_ACK;
                    end else begin
                        m_last = m_ch;
                        m_ph   = P_IDLE;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        drive();
        @(negedge clk_i);
        check_cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ack"}, 64'(a2s_ack_o), 64'd0);
        check_eq({tag, "_val"}, 64'(arb_val_o), 64'd0);
        check_eq({tag, "_id"}, 64'(arb_id_o), 64'd0);
        check_eq({tag, "_data"}, 64'(arb_data_o), 64'd0);
        check_eq({tag, "_err"}, 64'(arb_err_o), 64'd0);
    endtask

    task automatic start_directed(input logic [NCH*2-1:0] pr);
        rand_cfg  = 0;
        en_cfg    = 3'b111;
        prio_cfg  = pr;
        ready_pct = 100;
        err_pct   = 0;
        push_pct  = 0;
        glog.delete();
        wlog.delete();
        rec = 1;
    endtask

    initial begin
        rstn_i      = 1'b0;
        slv_req_i   = '0;
        slv_val_i   = '0;
        slv_data_i  = '0;
        slv_prio_i  = '0;
        slv_en_i    = '0;
        fmt_ready_i = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            wr[n] = 0;
            rd[n] = 0;
        end
        m_ph = P_IDLE; m_ch = 0; m_cnt = 0; m_last = NCH - 1; m_hold = 1'b0; m_data = '0;
        en_cfg = '0; prio_cfg = '0; rand_cfg = 0; ready_pct = 100; err_pct = 0; push_pct = 0; rec = 0;

        repeat (3) @(negedge clk_i);
        check_outputs_zero("rst");
        #1 rstn_i = 1'b1;

        // Round-robin: equal priorities, 8 words each, bursts of BL.
        start_directed(6'b00_00_00);
        for (int n = 0; n < NCH; n++) for (int i = 0; i < 8; i++) push(n, $urandom);
        repeat (90) step();
        rec = 0;
        check_eq("rr_grants", 64'(glog.size()), 64'd6);
        foreach (glog[i]) check_eq("rr_order", 64'(glog[i]), 64'(i % 3));
        check_eq("rr_words", 64'(wlog.size()), 64'd24);
        foreach (wlog[i]) check_eq("rr_id", 64'(wlog[i]), 64'((i / 4) % 3));

        // Single word on ch1.
        start_directed(6'b00_00_00);
        push(1, 32'hA5A5_0001);
        repeat (8) step();
        rec = 0;
        check_eq("single_grants", 64'(glog.size()), 64'd1);
        check_eq("single_words", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) check_eq("single_id", 64'(wlog[0]), 64'd1);

        // Priority: ch2 (prio 1) before ch0 (prio 2).
        start_directed({2'd1, 2'd0, 2'd2});
        for (int i = 0; i < 5; i++) begin
            push(0, $urandom);
            push(2, $urandom);
        end
        repeat (60) step();
        rec = 0;
        check_eq("prio_words", 64'(wlog.size()), 64'd10);
        foreach (wlog[i]) check_eq("prio_id", 64'(wlog[i]), (i < 5) ? 64'd2 : 64'd0);

        // Randomized traffic with backpressure, enable/priority churn and missing val.
        rand_cfg = 1; ready_pct = 60; err_pct = 10; push_pct = 25;
        repeat (800) step();

        // Ten-cycle stall in SEND.
        for (int i = 0; i < 300 && m_ph != P_SEND; i++) step();
        check_eq("stall_reach", 64'(m_ph == P_SEND), 64'd1);
        ready_pct = 0;
        repeat (10) step();
        check_eq("stall_val", 64'(arb_val_o), 64'd1);
        ready_pct = 60;
        repeat (400) step();

        // Asynchronous reset while a word is waiting in SEND.
        ready_pct = 0;
        for (int i = 0; i < 300 && !arb_val_o; i++) step();
        check_eq("rst2_reach", 64'(arb_val_o), 64'd1);
        #2 rstn_i = 1'b0;
        #1;
        check_outputs_zero("rst2");
        slv_req_i = '0;
        slv_val_i = '0;
        for (int n = 0; n < NCH; n++) rd[n] = wr[n];
        m_ph = P_IDLE; m_cnt = 0; m_last = NCH - 1; m_hold = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst2_hold_val", 64'(arb_val_o), 64'd0);
        #1 rstn_i = 1'b1;

        // After reset the round-robin pointer restarts at ch0: ch1 beats ch2 at equal priority.
        start_directed({2'd0, 2'd0, 2'd1});
        for (int n = 0; n < NCH; n++) begin
            push(n, $urandom);
            push(n, $urandom);
        end
        repeat (40) step();
        rec = 0;
        check_eq("post_rst_first", (glog.size() > 0) ? 64'(glog[0]) : 64'hFFFF, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
